// File: rtl/clk_duty_monitor.sv
// Measures high time and period of a clk-synchronous signal, flags stuck levels and counter overflow.
// Optional duty/period comparator enabled by defining DUTY_CHECK_EN.
module clk_duty_monitor #(
  parameter int CNT_W      = 16,
  parameter int TIMEOUT    = 1024,
  parameter int EXP_HIGH   = 3,
  parameter int EXP_PERIOD = 5,
  parameter int TOL        = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             sig_in,
  output logic             meas_valid,
  output logic [CNT_W-1:0] high_cnt,
  output logic [CNT_W-1:0] period_cnt,
  output logic             ovf,
  output logic             stuck_hi,
  output logic             stuck_lo,
  output logic             duty_err
);

  localparam int AGE_W = $clog2(TIMEOUT + 1);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ARM  = 2'd1;
  localparam logic [1:0] S_HIGH = 2'd2;
  localparam logic [1:0] S_LOW  = 2'd3;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [AGE_W-1:0] AGE_LAST = AGE_W'(TIMEOUT - 1);

  logic [1:0]       state_q, state_d;
  logic             sig_d_q;
  logic [CNT_W-1:0] h_q, h_d, p_q, p_d;
  logic             sat_q, sat_d;
  logic [AGE_W-1:0] age_q, age_d;
  logic             mv_q, mv_d;
  logic [CNT_W-1:0] high_q, high_d, period_q, period_d;
  logic             ovf_q, ovf_d;
  logic             shi_q, shi_d, slo_q, slo_d;

  logic rise, fall, timeout, publish, do_timeout;

  assign rise    = sig_in & ~sig_d_q;
  assign fall    = ~sig_in & sig_d_q;
  // An edge in the expiry cycle resets the age and suppresses the stuck flag.
  assign timeout = ~(rise | fall) & (age_q == AGE_LAST);

  always_comb begin
    state_d    = state_q;
    h_d        = h_q;
    p_d        = p_q;
    sat_d      = sat_q;
    age_d      = (rise | fall) ? '0 : age_q + 1'b1;
    mv_d       = 1'b0;
    high_d     = high_q;
    period_d   = period_q;
    ovf_d      = ovf_q;
    shi_d      = shi_q;
    slo_d      = slo_q;
    publish    = 1'b0;
    do_timeout = 1'b0;

    if (!en) begin
      state_d = S_IDLE;
      h_d     = '0;
      p_d     = '0;
      sat_d   = 1'b0;
      age_d   = '0;
      ovf_d   = 1'b0;
      shi_d   = 1'b0;
      slo_d   = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_ARM;
          h_d     = '0;
          p_d     = '0;
          sat_d   = 1'b0;
          age_d   = '0;
        end
        S_ARM: begin
          if (rise) begin
            state_d = S_HIGH;
            h_d     = CNT_W'(1);
            p_d     = CNT_W'(1);
            sat_d   = 1'b0;
          end else if (timeout) begin
            do_timeout = 1'b1;
          end
        end
        S_HIGH: begin
          if (fall) begin
            state_d = S_LOW;
            p_d     = (p_q == CNT_MAX) ? p_q : p_q + 1'b1;
            sat_d   = sat_q | (p_q == CNT_MAX);
          end else if (timeout) begin
            do_timeout = 1'b1;
          end else begin
            h_d   = (h_q == CNT_MAX) ? h_q : h_q + 1'b1;
            p_d   = (p_q == CNT_MAX) ? p_q : p_q + 1'b1;
            sat_d = sat_q | (h_q == CNT_MAX) | (p_q == CNT_MAX);
          end
        end
        default: begin // S_LOW
          if (rise) begin
            publish = 1'b1;
            state_d = S_HIGH;
            h_d     = CNT_W'(1);
            p_d     = CNT_W'(1);
            sat_d   = 1'b0;
          end else if (timeout) begin
            do_timeout = 1'b1;
          end else begin
            p_d   = (p_q == CNT_MAX) ? p_q : p_q + 1'b1;
            sat_d = sat_q | (p_q == CNT_MAX);
          end
        end
      endcase
    end

    if (do_timeout) begin
      state_d = S_ARM;
      age_d   = '0;
      h_d     = '0;
      p_d     = '0;
      sat_d   = 1'b0;
      if (sig_in) shi_d = 1'b1;
      else        slo_d = 1'b1;
    end

    if (publish) begin
      mv_d     = 1'b1;
      high_d   = h_q;
      period_d = p_q;
      ovf_d    = sat_q;
      shi_d    = 1'b0;
      slo_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      sig_d_q  <= 1'b0;
      h_q      <= '0;
      p_q      <= '0;
      sat_q    <= 1'b0;
      age_q    <= '0;
      mv_q     <= 1'b0;
      high_q   <= '0;
      period_q <= '0;
      ovf_q    <= 1'b0;
      shi_q    <= 1'b0;
      slo_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sig_d_q  <= sig_in;
      h_q      <= h_d;
      p_q      <= p_d;
      sat_q    <= sat_d;
      age_q    <= age_d;
      mv_q     <= mv_d;
      high_q   <= high_d;
      period_q <= period_d;
      ovf_q    <= ovf_d;
      shi_q    <= shi_d;
      slo_q    <= slo_d;
    end
  end

`ifdef DUTY_CHECK_EN
  logic        derr_q, derr_d;
  logic [31:0] h_dev, p_dev;

  always_comb begin
    h_dev = (32'(h_q) >= 32'(EXP_HIGH))   ? 32'(h_q) - 32'(EXP_HIGH)   : 32'(EXP_HIGH) - 32'(h_q);
    p_dev = (32'(p_q) >= 32'(EXP_PERIOD)) ? 32'(p_q) - 32'(EXP_PERIOD) : 32'(EXP_PERIOD) - 32'(p_q);
    derr_d = derr_q;
    if (!en)
      derr_d = 1'b0;
    else if (publish)
      derr_d = (h_dev > 32'(TOL)) | (p_dev > 32'(TOL)) | sat_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) derr_q <= 1'b0;
    else     derr_q <= derr_d;
  end

  assign duty_err = derr_q;
`else
  assign duty_err = 1'b0;
`endif

  assign meas_valid = mv_q;
  assign high_cnt   = high_q;
  assign period_cnt = period_q;
  assign ovf        = ovf_q;
  assign stuck_hi   = shi_q;
  assign stuck_lo   = slo_q;

endmodule

// File: tb/tb_clk_duty_monitor.sv
// Bench for clk_duty_monitor: waveform table and corner sequences on a default instance,
// random stimulus against a history-based reference model on a narrow-counter instance.
module tb_clk_duty_monitor;

  localparam int T1   = 64;
  localparam int W1   = 4;
  localparam int MAX1 = (1 << W1) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst0 = 1'b1, en0 = 1'b0, sig0 = 1'b0;
  logic        mv0, ovf0, shi0, slo0, derr0;
  logic [15:0] hc0, pc0;
  logic        rst1 = 1'b1, en1 = 1'b0, sig1 = 1'b0;
  logic        mv1, ovf1, shi1, slo1, derr1;
  logic [W1-1:0] hc1, pc1;

  clk_duty_monitor #(.CNT_W(16), .TIMEOUT(1024), .EXP_HIGH(3), .EXP_PERIOD(5), .TOL(0)) u0 (
    .clk(clk), .rst(rst0), .en(en0), .sig_in(sig0), .meas_valid(mv0), .high_cnt(hc0),
    .period_cnt(pc0), .ovf(ovf0), .stuck_hi(shi0), .stuck_lo(slo0), .duty_err(derr0));

  clk_duty_monitor #(.CNT_W(W1), .TIMEOUT(T1), .EXP_HIGH(3), .EXP_PERIOD(5), .TOL(0)) u1 (
    .clk(clk), .rst(rst1), .en(en1), .sig_in(sig1), .meas_valid(mv1), .high_cnt(hc1),
    .period_cnt(pc1), .ovf(ovf1), .stuck_hi(shi1), .stuck_lo(slo1), .duty_err(derr1));

  int checks = 0, errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_zero0(input string tag);
    chk({tag, " meas_valid"}, 32'(mv0), 0);
    chk({tag, " high_cnt"},   32'(hc0), 0);
    chk({tag, " period_cnt"}, 32'(pc0), 0);
    chk({tag, " ovf"},        32'(ovf0), 0);
    chk({tag, " stuck_hi"},   32'(shi0), 0);
    chk({tag, " stuck_lo"},   32'(slo0), 0);
    chk({tag, " duty_err"},   32'(derr0), 0);
  endtask

  task automatic step0(input logic e, input logic s);
    en0 = e; sig0 = s;
    @(posedge clk); #1;
  endtask

  task automatic reset0();
    rst0 = 1'b1; en0 = 1'b0; sig0 = 1'b0;
    @(posedge clk); #1;
    rst0 = 1'b0;
  endtask

  // Reference model: keeps the sampled levels of the open period and derives
  // results by counting them; stuck detection by distance to the last edge.
  logic m_prev;
  bit   m_arm, m_inp;
  int   m_hist[$];
  int   m_now, m_last;
  int   m_mv, m_h, m_p, m_ovf, m_shi, m_slo, m_derr;

  task automatic model_reset();
    m_prev = 1'b0; m_arm = 0; m_inp = 0; m_hist.delete();
    m_now = 0; m_last = 0;
    m_mv = 0; m_h = 0; m_p = 0; m_ovf = 0; m_shi = 0; m_slo = 0; m_derr = 0;
  endtask

  task automatic model_step(input logic e, input logic s);
    bit rise, fall;
    int ones, len;
    m_now++;
    m_mv = 0;
    rise = s && !m_prev;
    fall = !s && m_prev;
    if (!e) begin
      m_arm = 0; m_inp = 0; m_hist.delete();
      m_ovf = 0; m_shi = 0; m_slo = 0; m_derr = 0;
    end else if (!m_arm) begin
      m_arm = 1; m_last = m_now;
    end else begin
      if (rise || fall) m_last = m_now;
      if (rise) begin
        if (m_inp) begin
          ones = 0;
          foreach (m_hist[i]) ones += m_hist[i];
          len   = m_hist.size();
          m_h   = (ones > MAX1) ? MAX1 : ones;
          m_p   = (len > MAX1) ? MAX1 : len;
          m_ovf = (len > MAX1);
          m_mv  = 1; m_shi = 0; m_slo = 0;
`ifdef DUTY_CHECK_EN
          m_derr = ((m_h > 3 ? m_h - 3 : 3 - m_h) > 0) || ((m_p > 5 ? m_p - 5 : 5 - m_p) > 0) || (m_ovf != 0);
`endif
        end
        m_hist.delete();
        m_hist.push_back(1);
        m_inp = 1;
      end else begin
        if (m_inp) m_hist.push_back(int'(s));
        if (!fall && (m_now - m_last == T1)) begin
          if (s) m_shi = 1; else m_slo = 1;
          m_inp = 0; m_hist.delete(); m_last = m_now;
        end
      end
    end
    m_prev = s;
  endtask

  task automatic cmp1();
    chk("u1 meas_valid", 32'(mv1),   32'(m_mv));
    chk("u1 high_cnt",   32'(hc1),   32'(m_h));
    chk("u1 period_cnt", 32'(pc1),   32'(m_p));
    chk("u1 ovf",        32'(ovf1),  32'(m_ovf));
    chk("u1 stuck_hi",   32'(shi1),  32'(m_shi));
    chk("u1 stuck_lo",   32'(slo1),  32'(m_slo));
    chk("u1 duty_err",   32'(derr1), 32'(m_derr));
  endtask

  task automatic cycle1(input logic e, input logic s);
    en1 = e; sig1 = s;
    @(posedge clk);
    model_step(e, s);
    #1;
    cmp1();
  endtask

  task automatic reset1();
    rst1 = 1'b1; en1 = 1'b0; sig1 = 1'b0;
    #2;
    model_reset();
    cmp1();
    @(posedge clk); #1;
    rst1 = 1'b0;
  endtask

  typedef struct {
    int hi; int lo; int exp_h; int exp_p; bit exp_duty;
  } vec_t;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[4];
    int   idx, first, last, nmv, fh, fp, fo, fd, dexp, per;
    logic lvl;
    int   r, sel, len, n, cyc;
    logic [3:0] resume [8];

    tbl[0] = '{3, 2, 3, 5, 1'b0};
    tbl[1] = '{1, 1, 1, 2, 1'b1};
    tbl[2] = '{4, 1, 4, 5, 1'b1};
    tbl[3] = '{2, 5, 2, 7, 1'b1};
    model_reset();
    #1;

    // Waveform table on u0
    foreach (tbl[t]) begin
      reset0();
      chk_zero0($sformatf("row%0d reset", t));
      step0(1, 0); step0(1, 0);
      per = tbl[t].hi + tbl[t].lo;
      idx = 0; first = -1; last = -1; nmv = 0;
      fh = 0; fp = 0; fo = 0; fd = 0;
      for (int k = 0; k < 4; k++)
        for (int c = 0; c < per; c++) begin
          step0(1, c < tbl[t].hi);
          if (mv0) begin
            nmv++;
            if (first < 0) begin
              first = idx; fh = hc0; fp = pc0; fo = ovf0; fd = derr0;
            end else
              chk($sformatf("row%0d pulse gap", t), 32'(idx - last), 32'(per));
            last = idx;
          end
          idx++;
        end
`ifdef DUTY_CHECK_EN
      dexp = tbl[t].exp_duty;
`else
      dexp = 0;
`endif
      chk($sformatf("row%0d first pulse", t), 32'(first), 32'(per));
      chk($sformatf("row%0d pulses", t), 32'(nmv), 3);
      chk($sformatf("row%0d high_cnt", t), 32'(fh), 32'(tbl[t].exp_h));
      chk($sformatf("row%0d period_cnt", t), 32'(fp), 32'(tbl[t].exp_p));
      chk($sformatf("row%0d ovf", t), 32'(fo), 0);
      chk($sformatf("row%0d duty_err", t), 32'(fd), 32'(dexp));
    end

    // Stuck high on u0: rise, then 1100 cycles high
    reset0();
    step0(1, 0); step0(1, 0);
    nmv = 0;
    for (int j = 0; j < 1100; j++) begin
      step0(1, 1);
      if (mv0) nmv++;
      if (j == 1023) chk("stuck_hi before timeout", 32'(shi0), 0);
      if (j == 1024) chk("stuck_hi at timeout", 32'(shi0), 1);
    end
    chk("stuck no pulses", 32'(nmv), 0);
    chk("stuck_hi held", 32'(shi0), 1);
    chk("stuck_lo clear", 32'(slo0), 0);
    resume = '{4'd0, 4'd0, 4'd1, 4'd1, 4'd1, 4'd0, 4'd0, 4'd1};
    for (int j = 0; j < 8; j++) begin
      step0(1, resume[j][0]);
      if (j == 6) chk("stuck_hi before publish", 32'(shi0), 1);
    end
    chk("resume meas_valid", 32'(mv0), 1);
    chk("resume stuck_hi cleared", 32'(shi0), 0);
    chk("resume high_cnt", 32'(hc0), 3);
    chk("resume period_cnt", 32'(pc0), 5);

    // Asynchronous reset while HIGH
    reset0();
    step0(1, 0); step0(1, 0);
    resume = '{4'd1, 4'd1, 4'd1, 4'd0, 4'd0, 4'd1, 4'd1, 4'd1};
    for (int j = 0; j < 7; j++) step0(1, resume[j][0]);
    chk("preB high_cnt", 32'(hc0), 3);
    rst0 = 1'b1;
    #1;
    chk_zero0("async reset");
    @(posedge clk); #1;
    rst0 = 1'b0;
    en0 = 1'b0;

    // en dropped in LOW, coincident with the terminating rise
    reset0();
    step0(1, 0); step0(1, 0);
    for (int j = 0; j < 8; j++) step0(1, resume[j][0]);
    step0(1, 0);
    chk("preC period_cnt", 32'(pc0), 5);
    nmv = 0;
    step0(0, 1); if (mv0) nmv++;
    step0(0, 0); if (mv0) nmv++;
    step0(0, 1); if (mv0) nmv++;
    chk("en drop no pulse", 32'(nmv), 0);
    chk("en drop high hold", 32'(hc0), 3);
    chk("en drop period hold", 32'(pc0), 5);
    chk("en drop stuck_hi", 32'(shi0), 0);
    chk("en drop stuck_lo", 32'(slo0), 0);
    chk("en drop duty_err", 32'(derr0), 0);
    rst0 = 1'b1;

    // Saturation on u1 (4-bit counters): 20 high, 2 low
    reset1();
    cycle1(1, 0); cycle1(1, 0);
    repeat (20) cycle1(1, 1);
    repeat (2) cycle1(1, 0);
    cycle1(1, 1);
    chk("sat meas_valid", 32'(mv1), 1);
    chk("sat high_cnt", 32'(hc1), 15);
    chk("sat period_cnt", 32'(pc1), 15);
    chk("sat ovf", 32'(ovf1), 1);
`ifdef DUTY_CHECK_EN
    chk("sat duty_err", 32'(derr1), 1);
`else
    chk("sat duty_err", 32'(derr1), 0);
`endif

    // Random runs on u1 against the model
    lvl = 1'b0;
    cyc = 0;
    while (cyc < 3000) begin
      r = $urandom_range(0, 299);
      if (r == 0) begin
        reset1();
      end else if (r < 4) begin
        n = $urandom_range(1, 3);
        repeat (n) begin cycle1(0, lvl); cyc++; end
      end else begin
        lvl = ~lvl;
        sel = $urandom_range(0, 99);
        len = (sel < 70) ? $urandom_range(1, 5) : (sel < 92) ? $urandom_range(6, 24) : $urandom_range(40, 80);
        repeat (len) begin cycle1(1, lvl); cyc++; end
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
